// File: rtl/ttt_button_conditioner.sv
// ---------------------------------------------------------------------------
// ttt_button_conditioner
//   Input conditioning for the TicTacToe game core. Each of the two raw
//   push-buttons is synchronised (2 flops), debounced by a four-state channel
//   FSM and turned into a single-cycle accept. A small arbiter guarantees the
//   game core never sees sel and next high in the same cycle.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a level must be stable before it is accepted (>= 2)
//   BTN_ACTIVE_LOW   1: raw button reads 0 when pressed; 0: reads 1 when pressed
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   btn_sel_raw   raw select button, asynchronous to clk
//   btn_next_raw  raw next button, asynchronous to clk
//   sel           one-cycle pulse per accepted select press
//   next          one-cycle pulse per accepted next press
//   sel_level     debounced select level, 1 = pressed
//   next_level    debounced next level, 1 = pressed
// ---------------------------------------------------------------------------
module ttt_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sel_raw,
  input  logic btn_next_raw,
  output logic sel,
  output logic next,
  output logic sel_level,
  output logic next_level
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned NCH     = 2;
  localparam int unsigned CH_SEL  = 0;
  localparam int unsigned CH_NEXT = 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } chan_state_e;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync2_q;
  logic [NCH-1:0]   pressed;

  chan_state_e      state_q [NCH];
  chan_state_e      state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];

  logic [NCH-1:0]   accept;
  logic [NCH-1:0]   level_d;
  logic [NCH-1:0]   level_q;

  logic             sel_d;
  logic             sel_q;
  logic             next_d;
  logic             next_q;
  logic             sel_pend_d;
  logic             sel_pend_q;
  logic             next_pend_d;
  logic             next_pend_q;

  assign raw = {btn_next_raw, btn_sel_raw};

  // Two-flop synchroniser per button; resets to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= {NCH{BTN_ACTIVE_LOW}};
      sync2_q <= {NCH{BTN_ACTIVE_LOW}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ {NCH{BTN_ACTIVE_LOW}};

  // Channel FSM state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // Channel FSM next state; the terminal compare stops the counter, so it
  // never wraps.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (pressed[c]) begin
            state_d[c] = ST_PRESS_WAIT;
            cnt_d[c]   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed[c]) begin
            state_d[c] = ST_IDLE;
          end else if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = ST_PRESSED;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!pressed[c]) begin
            state_d[c] = ST_RELEASE_WAIT;
            cnt_d[c]   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (pressed[c]) begin
            state_d[c] = ST_PRESSED;
          end else if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = ST_IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          state_d[c] = ST_IDLE;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  // Channel FSM outputs: accept fires on the PRESS_WAIT -> PRESSED transition
  // only, so a release glitch (RELEASE_WAIT -> PRESSED) never re-triggers.
  always_comb begin
    accept  = '0;
    level_d = '0;
    for (int c = 0; c < NCH; c++) begin
      accept[c]  = (state_q[c] == ST_PRESS_WAIT) && pressed[c] &&
                   (cnt_q[c] == CNT_LAST);
      level_d[c] = (state_d[c] == ST_PRESSED) ||
                   (state_d[c] == ST_RELEASE_WAIT);
    end
  end

  // Exclusion arbiter: a pending next goes first, then sel, then a fresh
  // next. Whatever loses is held in a pending flag for the following cycle.
  always_comb begin
    sel_d       = 1'b0;
    next_d      = 1'b0;
    sel_pend_d  = 1'b0;
    next_pend_d = 1'b0;
    if (next_pend_q) begin
      next_d      = 1'b1;
      sel_pend_d  = sel_pend_q | accept[CH_SEL];
      next_pend_d = accept[CH_NEXT];
    end else if (sel_pend_q || accept[CH_SEL]) begin
      sel_d       = 1'b1;
      next_pend_d = accept[CH_NEXT];
    end else if (accept[CH_NEXT]) begin
      next_d      = 1'b1;
    end
  end

  // Registered outputs and pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q       <= 1'b0;
      next_q      <= 1'b0;
      sel_pend_q  <= 1'b0;
      next_pend_q <= 1'b0;
      level_q     <= '0;
    end else begin
      sel_q       <= sel_d;
      next_q      <= next_d;
      sel_pend_q  <= sel_pend_d;
      next_pend_q <= next_pend_d;
      level_q     <= level_d;
    end
  end

  assign sel        = sel_q;
  assign next       = next_q;
  assign sel_level  = level_q[CH_SEL];
  assign next_level = level_q[CH_NEXT];

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_ttt_button_conditioner
//   Directed bench for ttt_button_conditioner with DEBOUNCE_CYCLES=4 and
//   active-low buttons, so a stable press is accepted on edge 7 after it is
//   first sampled. Outputs are compared as {sel, next, sel_level, next_level}.
// ---------------------------------------------------------------------------
module tb_ttt_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int          LAT = 7;

  logic clk;
  logic rst;
  logic btn_sel_raw;
  logic btn_next_raw;
  logic sel;
  logic next;
  logic sel_level;
  logic next_level;

  int n_cmp;
  int n_err;

  ttt_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_sel_raw (btn_sel_raw),
    .btn_next_raw(btn_next_raw),
    .sel         (sel),
    .next        (next),
    .sel_level   (sel_level),
    .next_level  (next_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step and compare outputs; also checks sel/next never coincide.
  task automatic step_check(input string tag, input logic [3:0] exp);
    step();
    check(tag, {sel, next, sel_level, next_level}, exp);
    check({tag, "_excl"}, {3'b000, sel & next}, 4'b0000);
  endtask

  // Release sel and wait for its level to fall on edge LAT.
  task automatic release_sel(input string tag);
    btn_sel_raw = 1'b1;
    for (int e = 1; e <= 10; e++)
      step_check($sformatf("%s[%0d]", tag, e), {2'b00, e < LAT, 1'b0});
  endtask

  initial begin
    logic [4:0] bounce;
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    btn_sel_raw  = 1'b1;
    btn_next_raw = 1'b1;

    // Reset held, then released with both buttons up: nothing happens.
    for (int e = 1; e <= 3; e++)
      step_check($sformatf("reset_hold[%0d]", e), 4'b0000);
    rst = 1'b1;
    for (int e = 1; e <= 20; e++)
      step_check($sformatf("reset_idle[%0d]", e), 4'b0000);

    // Clean press held 30 cycles: single pulse on edge 7, level from 7.
    btn_sel_raw = 1'b0;
    for (int e = 1; e <= 30; e++)
      step_check($sformatf("clean_press[%0d]", e), {e == LAT, 1'b0, e >= LAT, 1'b0});
    release_sel("clean_release");

    // Press bounce 0,0,1,0,1 then held 0.
    bounce = 5'b10100;  // bit i = value of cycle i
    for (int i = 0; i < 5; i++) begin
      btn_sel_raw = bounce[i];
      step_check($sformatf("bounce[%0d]", i), 4'b0000);
    end
    btn_sel_raw = 1'b0;
    for (int e = 1; e <= 12; e++)
      step_check($sformatf("bounce_press[%0d]", e), {e == LAT, 1'b0, e >= LAT, 1'b0});

    // Release glitch of 2 cycles while pressed: level stays, no new pulse.
    btn_sel_raw = 1'b1;
    step_check("glitch[0]", 4'b0010);
    step_check("glitch[1]", 4'b0010);
    btn_sel_raw = 1'b0;
    for (int e = 1; e <= 12; e++)
      step_check($sformatf("glitch_hold[%0d]", e), 4'b0010);
    release_sel("glitch_release");

    // Simultaneous press: sel on edge 7, next deferred to edge 8.
    btn_sel_raw  = 1'b0;
    btn_next_raw = 1'b0;
    for (int e = 1; e <= 12; e++)
      step_check($sformatf("simul[%0d]", e), {e == LAT, e == LAT + 1, e >= LAT, e >= LAT});
    btn_sel_raw  = 1'b1;
    btn_next_raw = 1'b1;
    for (int e = 1; e <= 10; e++)
      step_check($sformatf("simul_release[%0d]", e), {2'b00, e < LAT, e < LAT});

    // Reset mid-debounce with next still held: one pulse 7 edges after release.
    btn_next_raw = 1'b0;
    for (int e = 1; e <= 4; e++)
      step_check($sformatf("pre_reset[%0d]", e), 4'b0000);
    rst = 1'b0;
    #1;
    check("in_reset", {sel, next, sel_level, next_level}, 4'b0000);
    step();
    rst = 1'b1;
    for (int e = 1; e <= 12; e++)
      step_check($sformatf("post_reset[%0d]", e), {1'b0, e == LAT, 1'b0, e >= LAT});
    btn_next_raw = 1'b1;
    for (int e = 1; e <= 10; e++)
      step_check($sformatf("post_reset_release[%0d]", e), {3'b000, e < LAT});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
